rf_wport_arbiter: RTL and testbench
===================================

# rf_wport_arbiter

Arbiter and scoreboard for the single register-file write port. It shares the port between the in-order writeback stage, including jal link writes, and the long-latency multiply/divide unit. It also tracks registers with an outstanding multiply/divide result so decode can stall on read-after-write hazards. It sits between writeback/MD and the register file, driving its write-enable, address, data and PC-for-trace inputs.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive cycles the MD unit may be denied before it is forced through (1..15)

Ports:
- CLK  in  1  clock
- reset  in  1  synchronous, active-high; clock CLK
- p_valid  in  1  writeback-stage write request
- p_link  in  1  jal link write; destination forced to 31
- p_addr  in  5  writeback destination (ignored when p_link)
- p_data  in  32  writeback data
- p_pc  in  32  writeback instruction PC
- p_ready  out  1  writeback request accepted this cycle
- m_valid  in  1  MD result request
- m_addr  in  5  MD destination
- m_data  in  32  MD result
- m_pc  in  32  MD instruction PC
- m_ready  out  1  MD request accepted this cycle
- m_issue  in  1  MD op issued; mark destination pending
- m_issue_addr  in  5  destination of issued MD op
- q_rs, q_rt  in  5  decode source registers
- q_rs_busy, q_rt_busy  out  1  source has a pending or in-flight write
- rf_we  out  1  register-file write enable
- rf_addr  out  5  register-file write address
- rf_data  out  32  register-file write data
- rf_pc  out  32  PC for the write trace

## Operation
- FSM states: NORMAL and FORCE_M.
- NORMAL: p_ready=1. m_ready = m_valid & ~p_valid. Writeback has priority.
- wait_cnt increments each cycle with m_valid & ~m_ready, saturating at STARVE_LIMIT. It clears on an m handshake or when m_valid=0.
- NORMAL→FORCE_M when wait_cnt==STARVE_LIMIT at a clock edge.
- FORCE_M: p_ready=0, m_ready=1. The state returns to NORMAL after the m handshake and wait_cnt clears.
- Handshake: a transfer occurs on valid&ready. The source holds its signals stable until accepted.
- Accepted transfer: rf_addr/rf_data/rf_pc are registered from the winner. rf_addr=31 for p_link.
- rf_we=1 for exactly one cycle per transfer, unless the effective address is 0. A $0 write still handshakes but holds rf_we=0.
- Scoreboard: 32 pending bits. Bit 0 is never set.
  - m_issue sets pending[m_issue_addr].
  - An m handshake clears pending[m_addr].
  - Set and clear of the same address in the same cycle: set wins.
- q_x_busy = pending[q_x] | (rf_we & rf_addr==q_x & q_x!=0). The in-flight write is covered until it lands.
- p_valid to a pending register is legal. It is written, and the bit stays set.

## Timing
- Latency: handshake in cycle t → rf_we/rf_addr/rf_data/rf_pc valid in t+1. The register file updates at the end of t+1.
- p_ready, m_ready, q_*_busy are combinational from state, inputs and registers. They have no path to rf_* outputs within the same cycle.
- Throughput: one write per cycle.
- Worst-case MD wait: STARVE_LIMIT+1 cycles.
- Reset, including mid-operation: state NORMAL, wait_cnt=0, all pending=0, rf_we=0, rf_addr=0, rf_data=0, rf_pc=0. A transfer accepted in the reset cycle is dropped.

## Structure
- Shared package cpu_pkg holds:
  - state enum {NORMAL, FORCE_M}
  - REG_AW=5, XLEN=32, LINK_REG=5'd31, ZERO_REG=5'd0
- Sub-module rf_pending_scoreboard contains the pending vector, set/clear logic and busy queries.
- The top level contains the FSM, wait counter and output register.

## Test plan
- p_valid=1, p_addr=8, p_data=0x1234, p_pc=0x3000 → p_ready=1; next cycle rf_we=1, rf_addr=8, rf_data=0x1234, rf_pc=0x3000.
- p_valid=1, p_link=1, p_addr=5, p_data=0x3008 → next cycle rf_addr=31, rf_data=0x3008.
- p_valid and m_valid held high for 6 cycles with STARVE_LIMIT=4 → p wins cycles 0–3; cycle 4 has FORCE_M, m_ready=1, p_ready=0; cycle 5 is back to NORMAL.
- m_issue with addr 9, then q_rs=9 → busy=1 until the cycle after the m handshake with m_addr=9 (rf_we cycle); busy=0 after.
- m_issue to addr 9 in the same cycle as an m handshake with m_addr=9 → pending[9] stays 1.
- p_valid to addr 0 → p_ready=1, rf_we stays 0.
- reset asserted while FORCE_M and pending[3]=1 → next cycle NORMAL, q busy for 3 is 0, rf_we=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants used by the register-file write-port logic.
// Holds the arbiter state encoding and the register-file geometry.
package cpu_pkg;

    localparam int REG_AW = 5;
    localparam int XLEN   = 32;
    localparam int NUM_REGS = 1 << REG_AW;

    localparam logic [REG_AW-1:0] LINK_REG = 5'd31;
    localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

    typedef enum logic {
        NORMAL,
        FORCE_M
    } arb_state_e;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [XLEN-1:0]   data;
        logic [XLEN-1:0]   pc;
    } wr_req_t;

    // jal link writes always target the link register, whatever p_addr says.
    function automatic logic [REG_AW-1:0] wb_dest(input logic link,
                                                  input logic [REG_AW-1:0] addr);
        return link ? LINK_REG : addr;
    endfunction

endpackage

// File: rtl/rf_pending_scoreboard.sv
// Pending-write scoreboard: one bit per register with an outstanding MD result,
// plus the busy queries decode uses to stall on read-after-write hazards.
module rf_pending_scoreboard
    import cpu_pkg::*;
(
    input  logic              CLK,
    input  logic              reset,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_addr,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_addr,
    input  logic              wr_we,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [REG_AW-1:0] q_rs,
    input  logic [REG_AW-1:0] q_rt,
    output logic              q_rs_busy,
    output logic              q_rt_busy
);

    logic [NUM_REGS-1:0] pending;

    // NOTE: the pending vector is plain flops (not a RAM), so it is cleared in one reset cycle.
    always_ff @(posedge CLK) begin
        if (reset) begin
            pending <= '0;
        end else begin
            // NOTE: non-blocking assignments; the later set overrides the clear, so set wins.
            if (clr_en)
                pending[clr_addr] <= 1'b0;
            if (set_en && set_addr != ZERO_REG)
                pending[set_addr] <= 1'b1;
        end
    end

    // A result being written this cycle is still invisible to a same-cycle read.
    function automatic logic busy_of(input logic [REG_AW-1:0] q);
        return pending[q] | (wr_we & (wr_addr == q) & (q != ZERO_REG));
    endfunction

    assign q_rs_busy = busy_of(q_rs);
    assign q_rt_busy = busy_of(q_rt);

endmodule

// File: rtl/rf_wport_arbiter.sv
// Arbitrates the single register-file write port between writeback and the MD unit,
// with a starvation guard for MD and a pending-result scoreboard for decode.
module rf_wport_arbiter
    import cpu_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              p_valid,
    input  logic              p_link,
    input  logic [REG_AW-1:0] p_addr,
    input  logic [XLEN-1:0]   p_data,
    input  logic [XLEN-1:0]   p_pc,
    output logic              p_ready,
    input  logic              m_valid,
    input  logic [REG_AW-1:0] m_addr,
    input  logic [XLEN-1:0]   m_data,
    input  logic [XLEN-1:0]   m_pc,
    output logic              m_ready,
    input  logic              m_issue,
    input  logic [REG_AW-1:0] m_issue_addr,
    input  logic [REG_AW-1:0] q_rs,
    input  logic [REG_AW-1:0] q_rt,
    output logic              q_rs_busy,
    output logic              q_rt_busy,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_addr,
    output logic [XLEN-1:0]   rf_data,
    output logic [XLEN-1:0]   rf_pc
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_e state;
    logic [3:0] wait_cnt;
    logic [3:0] wait_nxt;
    logic       p_fire;
    logic       m_fire;
    wr_req_t    win;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        p_ready = 1'b0;
        m_ready = 1'b0;
        unique case (state)
            NORMAL: begin
                p_ready = 1'b1;
                m_ready = m_valid & ~p_valid;
            end
            FORCE_M: begin
                p_ready = 1'b0;
                m_ready = 1'b1;
            end
        endcase
    end

    assign p_fire = p_valid & p_ready;
    assign m_fire = m_valid & m_ready;

    always_comb begin
        wait_nxt = wait_cnt;
        if (!m_valid || m_fire)
            wait_nxt = 4'd0;
        else if (wait_cnt != LIMIT)
            wait_nxt = wait_cnt + 4'd1;
    end

    // The two handshakes are mutually exclusive, so a simple select picks the winner.
    always_comb begin
        win.addr = wb_dest(p_link, p_addr);
        win.data = p_data;
        win.pc   = p_pc;
        if (m_fire) begin
            win.addr = m_addr;
            win.data = m_data;
            win.pc   = m_pc;
        end
    end

    // Entering FORCE_M on the edge where the count reaches the limit bounds MD wait at LIMIT+1.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state    <= NORMAL;
            wait_cnt <= 4'd0;
        end else begin
            wait_cnt <= wait_nxt;
            unique case (state)
                NORMAL:  if (wait_nxt == LIMIT) state <= FORCE_M;
                FORCE_M: if (m_fire)            state <= NORMAL;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            rf_we   <= 1'b0;
            rf_addr <= ZERO_REG;
            rf_data <= '0;
            rf_pc   <= '0;
        end else begin
            rf_we <= (p_fire | m_fire) & (win.addr != ZERO_REG);
            if (p_fire | m_fire) begin
                rf_addr <= win.addr;
                rf_data <= win.data;
                rf_pc   <= win.pc;
            end
        end
    end

    rf_pending_scoreboard u_scoreboard (
        .CLK       (CLK),
        .reset     (reset),
        .set_en    (m_issue),
        .set_addr  (m_issue_addr),
        .clr_en    (m_fire),
        .clr_addr  (m_addr),
        .wr_we     (rf_we),
        .wr_addr   (rf_addr),
        .q_rs      (q_rs),
        .q_rt      (q_rt),
        .q_rs_busy (q_rs_busy),
        .q_rt_busy (q_rt_busy)
    );

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter: expected writes go into a queue that a
// negedge monitor drains; handshake and busy outputs are checked per cycle.
module tb_rf_wport_arbiter;
    import cpu_pkg::*;

    localparam int STARVE_LIMIT = 4;

    logic        CLK;
    logic        reset;
    logic        p_valid, p_link;
    logic [4:0]  p_addr;
    logic [31:0] p_data, p_pc;
    logic        p_ready;
    logic        m_valid;
    logic [4:0]  m_addr;
    logic [31:0] m_data, m_pc;
    logic        m_ready;
    logic        m_issue;
    logic [4:0]  m_issue_addr;
    logic [4:0]  q_rs, q_rt;
    logic        q_rs_busy, q_rt_busy;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data, rf_pc;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    rf_wport_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .p_valid      (p_valid),
        .p_link       (p_link),
        .p_addr       (p_addr),
        .p_data       (p_data),
        .p_pc         (p_pc),
        .p_ready      (p_ready),
        .m_valid      (m_valid),
        .m_addr       (m_addr),
        .m_data       (m_data),
        .m_pc         (m_pc),
        .m_ready      (m_ready),
        .m_issue      (m_issue),
        .m_issue_addr (m_issue_addr),
        .q_rs         (q_rs),
        .q_rt         (q_rt),
        .q_rs_busy    (q_rs_busy),
        .q_rt_busy    (q_rt_busy),
        .rf_we        (rf_we),
        .rf_addr      (rf_addr),
        .rf_data      (rf_data),
        .rf_pc        (rf_pc)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called before the handshake edge: the write lands in the following cycle.
    task automatic expect_write(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.pc   = pc;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic step(input string name, input logic epr, input logic emr,
                        input logic ers, input logic ert, input int ewe = -1);
        @(negedge CLK);
        check({name, " p_ready"},   32'(p_ready),   32'(epr));
        check({name, " m_ready"},   32'(m_ready),   32'(emr));
        check({name, " q_rs_busy"}, 32'(q_rs_busy), 32'(ers));
        check({name, " q_rt_busy"}, 32'(q_rt_busy), 32'(ert));
        if (ewe >= 0)
            check({name, " rf_we"}, 32'(rf_we), 32'(ewe));
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        p_valid = 1'b0; p_link = 1'b0; p_addr = '0; p_data = '0; p_pc = '0;
        m_valid = 1'b0; m_addr = '0; m_data = '0; m_pc = '0;
        m_issue = 1'b0; m_issue_addr = '0;
        q_rs = '0; q_rt = '0;
    endtask

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: rf_addr %0d rf_data 0x%08h, expected no write",
                         rf_addr, rf_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_cycle", 32'(cyc), 32'(e.cyc));
                check("rf_addr", 32'(rf_addr), 32'(e.addr));
                check("rf_data", rf_data, e.data);
                check("rf_pc", rf_pc, e.pc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        idle();
        reset = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        @(negedge CLK);
        check("reset rf_we",   32'(rf_we),   32'd0);
        check("reset rf_addr", 32'(rf_addr), 32'd0);
        check("reset rf_data", rf_data,      32'd0);
        check("reset rf_pc",   rf_pc,        32'd0);
        check("reset p_ready", 32'(p_ready), 32'd1);
        @(posedge CLK);
        #1;
        reset = 1'b0;

        // Plain writeback, then jal link, then a lone MD result back to back.
        p_valid = 1; p_addr = 5'd8; p_data = 32'h1234; p_pc = 32'h3000;
        expect_write(5'd8, 32'h1234, 32'h3000);
        step("wb", 1, 0, 0, 0);
        p_link = 1; p_addr = 5'd5; p_data = 32'h3008; p_pc = 32'h3004;
        expect_write(5'd31, 32'h3008, 32'h3004);
        step("link", 1, 0, 0, 0);
        p_valid = 0; p_link = 0;
        m_valid = 1; m_addr = 5'd7; m_data = 32'hAAAA; m_pc = 32'h4000;
        expect_write(5'd7, 32'hAAAA, 32'h4000);
        step("md_alone", 1, 1, 0, 0);

        // Write to $0 handshakes but never raises rf_we.
        m_valid = 0;
        p_valid = 1; p_addr = 5'd0; p_data = 32'hDEAD; p_pc = 32'h5000;
        step("zero", 1, 0, 0, 0);
        idle();
        step("zero_after", 1, 0, 0, 0, 0);

        // Starvation: p wins four cycles, then MD is forced through.
        m_valid = 1; m_addr = 5'd12; m_data = 32'hBEEF; m_pc = 32'h6000;
        for (int i = 0; i < STARVE_LIMIT; i++) begin
            p_valid = 1; p_addr = 5'(16 + i); p_data = 32'(i); p_pc = 32'h7000 + 32'(4 * i);
            expect_write(5'(16 + i), 32'(i), 32'h7000 + 32'(4 * i));
            step("starve_p", 1, 0, 0, 0);
        end
        p_addr = 5'd20; p_data = 32'd4; p_pc = 32'h7010;
        expect_write(5'd12, 32'hBEEF, 32'h6000);
        step("force_m", 0, 1, 0, 0);
        m_addr = 5'd13; m_data = 32'hCAFE; m_pc = 32'h6004;
        expect_write(5'd20, 32'd4, 32'h7010);
        step("back_normal", 1, 0, 0, 0);
        p_valid = 0;
        expect_write(5'd13, 32'hCAFE, 32'h6004);
        step("m_after", 1, 1, 0, 0);
        idle();
        step("idle1", 1, 0, 0, 0);

        // Scoreboard: issue to 9, writeback to a pending reg, then MD clears it.
        m_issue = 1; m_issue_addr = 5'd9;
        step("issue9", 1, 0, 0, 0);
        m_issue = 0; q_rs = 5'd9; q_rt = 5'd10;
        step("pend9", 1, 0, 1, 0);
        p_valid = 1; p_addr = 5'd9; p_data = 32'h99; p_pc = 32'h8000;
        expect_write(5'd9, 32'h99, 32'h8000);
        step("p_to_pending", 1, 0, 1, 0);
        p_valid = 0;
        step("pend_inflight", 1, 0, 1, 0);
        m_valid = 1; m_addr = 5'd9; m_data = 32'h9999; m_pc = 32'h8004;
        expect_write(5'd9, 32'h9999, 32'h8004);
        step("m_clear9", 1, 1, 1, 0);
        m_valid = 0;
        step("inflight9", 1, 0, 1, 0);
        step("done9", 1, 0, 0, 0);

        // Same-cycle set and clear of 9: set wins.
        q_rs = 5'd0; q_rt = 5'd9;
        m_valid = 1; m_addr = 5'd9; m_data = 32'h1; m_pc = 32'h9000;
        m_issue = 1; m_issue_addr = 5'd9;
        expect_write(5'd9, 32'h1, 32'h9000);
        step("set_wins", 1, 1, 0, 0);
        m_valid = 0; m_issue = 0;
        step("set_wins_next", 1, 0, 0, 1);
        step("set_wins_hold", 1, 0, 0, 1);
        m_valid = 1; m_data = 32'h2; m_pc = 32'h9004;
        expect_write(5'd9, 32'h2, 32'h9004);
        step("clear9b", 1, 1, 0, 1);
        m_valid = 0;
        step("clear9b_inflight", 1, 0, 0, 1);
        step("clear9b_done", 1, 0, 0, 0);

        // Reset while in FORCE_M with pending[3] set.
        idle();
        q_rs = 5'd3;
        m_issue = 1; m_issue_addr = 5'd3;
        step("issue3", 1, 0, 0, 0);
        m_issue = 0;
        m_valid = 1; m_addr = 5'd3; m_data = 32'h33; m_pc = 32'hA000;
        for (int i = 0; i < STARVE_LIMIT; i++) begin
            p_valid = 1; p_addr = 5'(24 + i); p_data = 32'h100 + 32'(i); p_pc = 32'hB000 + 32'(4 * i);
            expect_write(5'(24 + i), 32'h100 + 32'(i), 32'hB000 + 32'(4 * i));
            step("pre_reset_p", 1, 0, 1, 0);
        end
        p_addr = 5'd28; p_data = 32'h104; p_pc = 32'hB010;
        reset = 1;
        step("force_in_reset", 0, 1, 1, 0);
        reset = 0;
        expect_write(5'd28, 32'h104, 32'hB010);
        step("after_reset", 1, 0, 0, 0, 0);
        idle();
        step("post_reset", 1, 0, 0, 0);
        step("drain", 1, 0, 0, 0, 0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
